program_mem_controller: RTL and testbench

- Sits directly upstream of the per-core instruction fetchers. Arbitrates read requests from NUM_CONSUMERS fetchers onto NUM_CHANNELS program-memory read channels.
- Read-only block: no write path.
- Consumer side uses the fetcher handshake: valid is held until ready, and data is captured on ready. Memory side uses the external program-memory valid/ready handshake.

---
 rtl/program_mem_controller.sv | 114 +++++++++++
 tb/tb_program_mem_controller.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_mem_controller.sv
// rtl/program_mem_controller.sv - round-robin arbiter of fetcher reads onto program-memory read channels
module program_mem_controller #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 1
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
  output logic [NUM_CHANNELS-1:0]                 mem_read_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]                 mem_read_ready,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data
);
  localparam int CW  = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam int CW1 = CW + 1;

  typedef enum logic [1:0] {IDLE, READ_WAITING, READ_RELAYING} state_t;

  state_t                           state [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0][CW-1:0]  owner;
  logic [NUM_CONSUMERS-1:0]         claimed;
  logic [CW-1:0]                    rr_ptr;

  logic [NUM_CHANNELS-1:0]          grant;
  logic [NUM_CHANNELS-1:0][CW-1:0]  grant_idx;
  logic [NUM_CONSUMERS-1:0]         taken;
  logic [CW-1:0]                    rr_next;
  logic [CW:0]                      scan_sum;
  logic [CW-1:0]                    scan_idx;

  // Lower channels claim first; 'taken' keeps a consumer from going to two channels at one edge.
  always_comb begin
    taken     = claimed;
    grant     = '0;
    grant_idx = '0;
    rr_next   = rr_ptr;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      if (state[ch] == IDLE) begin
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
          scan_sum = {1'b0, rr_ptr} + CW1'(k);
          if (scan_sum >= CW1'(NUM_CONSUMERS))
            scan_sum = scan_sum - CW1'(NUM_CONSUMERS);
          scan_idx = scan_sum[CW-1:0];
          if (!grant[ch] && consumer_read_valid[scan_idx] &&
              !consumer_read_ready[scan_idx] && !taken[scan_idx]) begin
            grant[ch]       = 1'b1;
            grant_idx[ch]   = scan_idx;
            taken[scan_idx] = 1'b1;
          end
        end
      end
      if (grant[ch]) begin
        if (grant_idx[ch] == CW'(NUM_CONSUMERS - 1))
          rr_next = '0;
        else
          rr_next = grant_idx[ch] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++)
        state[ch] <= IDLE;
      owner               <= '0;
      claimed             <= '0;
      rr_ptr              <= '0;
      consumer_read_ready <= '0;
      consumer_read_data  <= '0;
      mem_read_valid      <= '0;
      mem_read_address    <= '0;
    end else begin
      if (|grant)
        rr_ptr <= rr_next;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        case (state[ch])
          IDLE: begin
            if (grant[ch]) begin
              state[ch]                   <= READ_WAITING;
              owner[ch]                   <= grant_idx[ch];
              claimed[grant_idx[ch]]      <= 1'b1;
              mem_read_valid[ch]          <= 1'b1;
              mem_read_address[ch]        <= consumer_read_address[grant_idx[ch]];
            end
          end
          READ_WAITING: begin
            if (mem_read_ready[ch]) begin
              state[ch]                       <= READ_RELAYING;
              mem_read_valid[ch]              <= 1'b0;
              consumer_read_data[owner[ch]]   <= mem_read_data[ch];
              consumer_read_ready[owner[ch]]  <= 1'b1;
            end
          end
          READ_RELAYING: begin
            // Data is left in place after ready drops so the fetcher may sample it late.
            if (!consumer_read_valid[owner[ch]]) begin
              state[ch]                       <= IDLE;
              consumer_read_ready[owner[ch]]  <= 1'b0;
              claimed[owner[ch]]              <= 1'b0;
            end
          end
          default: state[ch] <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_program_mem_controller.sv
// tb/tb_program_mem_controller.sv - self-checking bench for program_mem_controller (1- and 2-channel builds)
module tb_program_mem_controller;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]       cv [2];
  logic [3:0][7:0]  ca [2];
  logic [1:0]       mr [2];
  logic [1:0][15:0] md [2];

  logic [3:0]       cr_a, cr_b;
  logic [3:0][15:0] cd_a, cd_b;
  logic [0:0]       mv_a;
  logic [1:0]       mv_b;
  logic [0:0][7:0]  ma_a;
  logic [1:0][7:0]  ma_b;

  logic [3:0]       cr_v [2];
  logic [3:0][15:0] cd_v [2];
  logic [1:0]       mv_v [2];
  logic [1:0][7:0]  ma_v [2];

  always_comb begin
    cr_v[0] = cr_a;
    cr_v[1] = cr_b;
    cd_v[0] = cd_a;
    cd_v[1] = cd_b;
    mv_v[0] = {1'b0, mv_a};
    mv_v[1] = mv_b;
    ma_v[0] = {8'h00, ma_a};
    ma_v[1] = ma_b;
  end

  program_mem_controller #(.NUM_CHANNELS(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .consumer_read_valid(cv[0]), .consumer_read_address(ca[0]),
    .consumer_read_ready(cr_a), .consumer_read_data(cd_a),
    .mem_read_valid(mv_a), .mem_read_address(ma_a),
    .mem_read_ready(mr[0][0:0]), .mem_read_data(md[0][0:0])
  );

  program_mem_controller #(.NUM_CHANNELS(2)) u_dut2 (
    .clk(clk), .reset(reset),
    .consumer_read_valid(cv[1]), .consumer_read_address(ca[1]),
    .consumer_read_ready(cr_b), .consumer_read_data(cd_b),
    .mem_read_valid(mv_b), .mem_read_address(ma_b),
    .mem_read_ready(mr[1]), .mem_read_data(md[1])
  );

  typedef struct {
    logic [3:0]  v;
    logic [7:0]  a;
    logic        mrdy;
    logic [15:0] mdat;
    logic [3:0]  e_rdy;
    logic        e_mv;
    logic [7:0]  e_ma;
    logic [15:0] e_cd0;
  } vec_t;

  vec_t tbl [$];
  int   total = 0;
  int   passed = 0;
  int   order [$];

  function automatic logic [15:0] rom(input logic [7:0] a);
    return {a ^ 8'h5A, ~a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    total++;
    $display("FAIL %s: bound exceeded or event missing", name);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      cv[d] = '0; ca[d] = '0; mr[d] = '0; md[d] = '0;
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Behavioural fetchers and memory: fetchers hold valid until ready, drop it one cycle later;
  // memory answers each request after a random delay with rom(address).
  task automatic traffic(input int d, input int ncyc, input bit fixed, input int nch);
    bit         served [4];
    bit         outst [4];
    int         wait_c [4];
    int         rdy_cnt [4];
    int         cnt [2];
    logic [7:0] gaddr [2];
    logic [1:0] mvp;
    logic [3:0] cvp;
    int         rr;
    int         ng;
    int         elig [$];
    rr = 0;
    mvp = mv_v[d];
    order.delete();
    for (int c = 0; c < 4; c++) begin
      served[c] = 0; outst[c] = 0; wait_c[c] = 0; rdy_cnt[c] = 0;
    end
    for (int ch = 0; ch < 2; ch++) begin
      cnt[ch] = 0; gaddr[ch] = '0;
    end
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      @(negedge clk);
      cvp = cv[d];
      elig.delete();
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (rr + k) % 4;
        if (cvp[c] && !outst[c]) elig.push_back(c);
      end
      ng = 0;
      for (int ch = 0; ch < nch; ch++) begin
        if (mv_v[d][ch] && !mvp[ch]) begin
          int g;
          g = fixed ? int'(ma_v[d][ch]) - 16 : int'(ma_v[d][ch][7:6]);
          if (ng < elig.size()) check("grant_order", g, elig[ng]);
          else fail("grant_extra");
          g = g & 3;
          check("grant_addr", ma_v[d][ch], ca[d][g]);
          outst[g] = 1;
          rr = (g + 1) % 4;
          order.push_back(g);
          gaddr[ch] = ma_v[d][ch];
          cnt[ch] = fixed ? 0 : int'($urandom_range(0, 3));
          ng++;
        end
      end
      for (int ch = 0; ch < nch; ch++) begin
        if (mr[d][ch]) begin
          check("mem_valid_drop", mv_v[d][ch], 0);
          mr[d][ch] = 1'b0;
        end else if (mv_v[d][ch]) begin
          if (mvp[ch]) check("mem_addr_hold", ma_v[d][ch], gaddr[ch]);
          if (cnt[ch] == 0) begin
            mr[d][ch] = 1'b1;
            md[d][ch] = rom(ma_v[d][ch]);
          end else cnt[ch]--;
        end
      end
      mvp = mv_v[d];
      for (int c = 0; c < 4; c++) begin
        if (cr_v[d][c]) rdy_cnt[c]++;
        else if (rdy_cnt[c] > 0) begin
          check("ready_len", rdy_cnt[c], 2);
          rdy_cnt[c] = 0;
        end
        if (cv[d][c]) begin
          if (served[c]) begin
            cv[d][c] = 1'b0; served[c] = 0; outst[c] = 0;
          end else if (cr_v[d][c]) begin
            check("data", cd_v[d][c], rom(ca[d][c]));
            served[c] = 1; wait_c[c] = 0;
          end else begin
            wait_c[c]++;
            if (wait_c[c] > 60) begin
              fail("wait_bound");
              cv[d][c] = 1'b0; outst[c] = 0; wait_c[c] = 0;
            end
          end
        end else if (!cr_v[d][c] && cyc < ncyc - 80 && (fixed || $urandom_range(0, 1) == 1)) begin
          cv[d][c] = 1'b1;
          ca[d][c] = fixed ? 8'(16 + c) : {2'(c), 6'($urandom)};
        end
      end
    end
    check("quiet_ready", cr_v[d], 0);
    check("quiet_mem_valid", mv_v[d], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //            v        a      mr    md        e_rdy    e_mv  e_ma   e_cd0
    tbl.push_back('{4'b0001, 8'h05, 1'b0, 16'h0000, 4'b0000, 1'b1, 8'h05, 16'h0000});
    tbl.push_back('{4'b0001, 8'h05, 1'b1, 16'hA1B2, 4'b0001, 1'b0, 8'h00, 16'hA1B2});
    tbl.push_back('{4'b0001, 8'h05, 1'b0, 16'h0000, 4'b0001, 1'b0, 8'h00, 16'hA1B2});
    tbl.push_back('{4'b0000, 8'h77, 1'b0, 16'h0000, 4'b0000, 1'b0, 8'h00, 16'hA1B2});
    tbl.push_back('{4'b0001, 8'h2A, 1'b0, 16'h0000, 4'b0000, 1'b1, 8'h2A, 16'hA1B2});
    for (int i = 0; i < 5; i++)
      tbl.push_back('{4'b0001, 8'h3C, 1'b0, 16'h0000, 4'b0000, 1'b1, 8'h2A, 16'hA1B2});
    tbl.push_back('{4'b0001, 8'h3C, 1'b1, 16'h5EED, 4'b0001, 1'b0, 8'h00, 16'h5EED});
    tbl.push_back('{4'b0000, 8'h3C, 1'b0, 16'h0000, 4'b0000, 1'b0, 8'h00, 16'h5EED});
    tbl.push_back('{4'b0000, 8'h3C, 1'b1, 16'hFFFF, 4'b0000, 1'b0, 8'h00, 16'h5EED});
    tbl.push_back('{4'b0001, 8'h44, 1'b0, 16'h0000, 4'b0000, 1'b1, 8'h44, 16'h5EED});
    tbl.push_back('{4'b0000, 8'h44, 1'b0, 16'h0000, 4'b0000, 1'b1, 8'h44, 16'h5EED});
    tbl.push_back('{4'b0000, 8'h44, 1'b1, 16'hBEEF, 4'b0001, 1'b0, 8'h00, 16'hBEEF});
    tbl.push_back('{4'b0000, 8'h44, 1'b0, 16'h0000, 4'b0000, 1'b0, 8'h00, 16'hBEEF});

    for (int d = 0; d < 2; d++) begin
      cv[d] = '0; ca[d] = '0; mr[d] = '0; md[d] = '0;
    end
    repeat (2) @(negedge clk);
    check("rst_mv1", mv_v[0], 0);
    check("rst_rdy1", cr_v[0], 0);
    check("rst_cd1", {31'b0, |cd_a}, 0);
    check("rst_mv2", mv_v[1], 0);
    check("rst_rdy2", cr_v[1], 0);
    check("rst_ma2", ma_b, 0);
    reset = 1'b1;

    foreach (tbl[i]) begin
      cv[0] = tbl[i].v;
      for (int c = 0; c < 4; c++) ca[0][c] = tbl[i].a;
      mr[0][0] = tbl[i].mrdy;
      md[0][0] = tbl[i].mdat;
      @(negedge clk);
      check($sformatf("vec%0d_ready", i), cr_a, tbl[i].e_rdy);
      check($sformatf("vec%0d_mem_valid", i), mv_a, tbl[i].e_mv);
      if (tbl[i].e_mv) check($sformatf("vec%0d_mem_addr", i), ma_a, tbl[i].e_ma);
      check($sformatf("vec%0d_data0", i), cd_a[0], tbl[i].e_cd0);
    end

    // reset while a read is outstanding, then a stale memory strobe
    cv[0] = 4'b0100; ca[0][2] = 8'h66; mr[0] = '0;
    @(negedge clk);
    check("midrst_pre_mv", mv_a, 1);
    check("midrst_pre_ma", ma_a, 8'h66);
    #2 reset = 1'b0;
    #1;
    check("midrst_mv", mv_a, 0);
    check("midrst_rdy", cr_a, 0);
    check("midrst_cd", {31'b0, |cd_a}, 0);
    cv[0] = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    mr[0][0] = 1'b1; md[0][0] = 16'hDEAD;
    @(negedge clk);
    check("stale_rdy", cr_a, 0);
    check("stale_mv", mv_a, 0);
    check("stale_cd", {31'b0, |cd_a}, 0);
    mr[0][0] = 1'b0;
    cv[0] = 4'b1010; ca[0][1] = 8'h51; ca[0][3] = 8'h53;
    @(negedge clk);
    check("post_rst_mv", mv_a, 1);
    check("post_rst_ma", ma_a, 8'h51);
    mr[0][0] = 1'b1; md[0][0] = 16'h5151;
    @(negedge clk);
    check("post_rst_rdy", cr_a, 4'b0010);
    check("post_rst_cd1", cd_a[1], 16'h5151);
    mr[0][0] = 1'b0; cv[0] = '0;
    @(negedge clk);
    check("post_rst_rdy_drop", cr_a, 0);

    // round-robin with all four fetchers re-requesting continuously
    do_reset();
    traffic(0, 120, 1'b1, 1);
    if (order.size() >= 5) begin
      check("rr_order0", order[0], 0);
      check("rr_order1", order[1], 1);
      check("rr_order2", order[2], 2);
      check("rr_order3", order[3], 3);
      check("rr_order4", order[4], 0);
    end else fail("rr_order_count");

    // two channels, simultaneous requests from consumers 1 and 3
    do_reset();
    cv[1] = 4'b1010; ca[1][1] = 8'h21; ca[1][3] = 8'h23;
    @(negedge clk);
    check("mc_mv", mv_b, 2'b11);
    check("mc_ma0", ma_b[0], 8'h21);
    check("mc_ma1", ma_b[1], 8'h23);
    mr[1] = 2'b11; md[1][0] = 16'h1111; md[1][1] = 16'h3333;
    @(negedge clk);
    check("mc_rdy", cr_b, 4'b1010);
    check("mc_cd1", cd_b[1], 16'h1111);
    check("mc_cd3", cd_b[3], 16'h3333);
    check("mc_mv_drop", mv_b, 2'b00);
    mr[1] = 2'b00; cv[1] = 4'b0000;
    @(negedge clk);
    check("mc_rdy_drop", cr_b, 4'b0000);
    cv[1] = 4'b1001; ca[1][0] = 8'h30; ca[1][3] = 8'h33;
    @(negedge clk);
    check("mc_rr_ma0", ma_b[0], 8'h30);
    check("mc_rr_ma1", ma_b[1], 8'h33);
    mr[1] = 2'b11;
    @(negedge clk);
    mr[1] = 2'b00; cv[1] = 4'b0000;
    repeat (2) @(negedge clk);

    do_reset();
    traffic(0, 400, 1'b0, 1);
    do_reset();
    traffic(1, 400, 1'b0, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
